// File: rtl/gmii_pkg.sv
`default_nettype none
// ==== gmii_pkg: control characters, framing state and word classifier (rev 1.0) ====
package gmii_pkg;
  localparam logic [7:0] IDLE_CHAR  = 8'h07;
  localparam logic [7:0] START_CHAR = 8'hFB;
  localparam logic [7:0] TERM_CHAR  = 8'hFD;
  localparam logic [7:0] ERROR_CHAR = 8'hFE;
  localparam int         MAX_LANES  = 32;

  typedef enum logic {FS_OUT = 1'b0, FS_IN = 1'b1} frame_state_t;
  typedef enum logic [2:0] {
    WK_IDLE = 3'd0, WK_START = 3'd1, WK_DATA = 3'd2, WK_TERM = 3'd3, WK_INVALID = 3'd4
  } word_kind_t;

  // A terminate word is recognised by its first control lane holding TERM with only idles above it.
  function automatic word_kind_t classify(input logic [MAX_LANES*8-1:0] data,
                                          input logic [MAX_LANES-1:0]   ctrl,
                                          input int                     lanes);
    logic       all_idle, all_data, is_start, seen_ctrl, term_ok, found_term;
    logic [7:0] b;
    word_kind_t kind;
    all_idle = 1'b1; all_data = 1'b1; is_start = 1'b1;
    seen_ctrl = 1'b0; term_ok = 1'b1; found_term = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes) begin
        b = data[i*8 +: 8];
        if (!ctrl[i] || b != IDLE_CHAR) all_idle = 1'b0;
        if (ctrl[i]) all_data = 1'b0;
        if (i == 0) begin
          if (!ctrl[i] || b != START_CHAR) is_start = 1'b0;
        end else if (ctrl[i]) begin
          is_start = 1'b0;
        end
        if (seen_ctrl) begin
          if (!ctrl[i] || b != IDLE_CHAR) term_ok = 1'b0;
        end else if (ctrl[i]) begin
          seen_ctrl  = 1'b1;
          found_term = (b == TERM_CHAR);
        end
      end
    end
    if (all_data)                   kind = WK_DATA;
    else if (all_idle)              kind = WK_IDLE;
    else if (is_start)              kind = WK_START;
    else if (found_term && term_ok) kind = WK_TERM;
    else                            kind = WK_INVALID;
    return kind;
  endfunction

  function automatic logic has_error_char(input logic [MAX_LANES*8-1:0] data,
                                          input logic [MAX_LANES-1:0]   ctrl,
                                          input int                     lanes);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < lanes && ctrl[i] && data[i*8 +: 8] == ERROR_CHAR) hit = 1'b1;
    end
    return hit;
  endfunction
endpackage
`default_nettype wire

// File: rtl/gmii_if.sv
`default_nettype none
// ==== gmii_if: one XGMII-style word stream (data lanes + per-lane control flags) (rev 1.0) ====
interface gmii_if #(parameter int DATA_WIDTH = 64) ();
  logic [DATA_WIDTH-1:0]   data;
  logic [DATA_WIDTH/8-1:0] ctrl;
  modport master (output data, output ctrl);
  modport slave  (input data, input ctrl);
endinterface
`default_nettype wire

// File: rtl/gmii_checker.sv
`default_nettype none
// ==== gmii_checker: per-word framing monitor with saturating frame/error counters (rev 1.0) ====
module gmii_checker
  import gmii_pkg::*;
#(
  parameter int DATA_WIDTH = 64
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  input  wire logic                    start_monitoring,
  input  wire logic [DATA_WIDTH-1:0]   data_in,
  input  wire logic [DATA_WIDTH/8-1:0] ctrl_in,
  output logic                         in_frame,
  output logic                         error_pulse,
  output logic [31:0]                  frame_count,
  output logic [31:0]                  error_count
);
  localparam int LANES = DATA_WIDTH / 8;

  frame_state_t            r_state, w_state_nxt;
  logic [MAX_LANES*8-1:0]  w_data_ext;
  logic [MAX_LANES-1:0]    w_ctrl_ext;
  word_kind_t              w_kind;
  logic                    w_err, w_good, r_err;
  logic [31:0]             r_frame_count, r_error_count;

  always_comb begin
    w_data_ext                   = '0;
    w_ctrl_ext                   = '0;
    w_data_ext[DATA_WIDTH-1:0]   = data_in;
    w_ctrl_ext[LANES-1:0]        = ctrl_in;
    w_kind      = classify(w_data_ext, w_ctrl_ext, LANES);
    w_state_nxt = r_state;
    w_err       = 1'b0;
    w_good      = 1'b0;
    case (r_state)
      FS_OUT: begin
        if (w_kind == WK_START)     w_state_nxt = FS_IN;
        else if (w_kind != WK_IDLE) w_err       = 1'b1;
      end
      FS_IN: begin
        case (w_kind)
          WK_DATA:  w_state_nxt = FS_IN;
          WK_TERM:  begin w_good = 1'b1; w_state_nxt = FS_OUT; end
          WK_START: w_err = 1'b1;
          default:  begin w_err = 1'b1; w_state_nxt = FS_OUT; end
        endcase
      end
      default: w_state_nxt = FS_OUT;
    endcase
    if (has_error_char(w_data_ext, w_ctrl_ext, LANES)) w_err = 1'b1;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state       <= FS_OUT;
      r_err         <= 1'b0;
      r_frame_count <= '0;
      r_error_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_err   <= w_err;
      if (start_monitoring && w_good && r_frame_count != 32'hFFFF_FFFF)
        r_frame_count <= r_frame_count + 32'd1;
      if (start_monitoring && w_err && r_error_count != 32'hFFFF_FFFF)
        r_error_count <= r_error_count + 32'd1;
    end
  end

`ifdef GMII_CHECKER_REPORT
  always_ff @(posedge clk) begin
    if (!rst_n && w_err) $error("gmii_checker t=%0t data=%h ctrl=%h", $time, data_in, ctrl_in);
  end
`endif

  assign in_frame    = (r_state == FS_IN);
  assign error_pulse = r_err;
  assign frame_count = r_frame_count;
  assign error_count = r_error_count;
endmodule
`default_nettype wire

// File: rtl/gmii_generator.sv
`default_nettype none
// ==== gmii_generator: pseudo-random idle/start/data/terminate word source (rev 1.0) ====
module gmii_generator
  import gmii_pkg::*;
#(
  parameter int          DATA_WIDTH            = 64,
  parameter int          DATA_CHAR_PROBABILITY = 80,
  parameter logic [15:0] SEED                  = 16'hACE1
) (
  input  wire logic                    clk,
  input  wire logic                    rst_n,
  output logic [DATA_WIDTH-1:0]        data_out,
  output logic [DATA_WIDTH/8-1:0]      ctrl_out
);
  localparam int LANES = DATA_WIDTH / 8;

  typedef enum logic [1:0] {GS_IDLE = 2'd0, GS_DATA = 2'd1, GS_GAP = 2'd2} gen_state_t;

  gen_state_t            r_state, w_state_nxt;
  logic [15:0]           w_lfsr;
  logic [DATA_WIDTH-1:0] r_data, w_data, w_payload;
  logic [LANES-1:0]      r_ctrl, w_ctrl;
  logic                  w_take_data;
  int                    w_k;

  gmii_lfsr #(.SEED(SEED)) u_lfsr (.clk(clk), .rst_n(rst_n), .o_lfsr(w_lfsr));

  always_comb begin
    w_payload = '0;
    // Even lanes carry the low LFSR byte, odd lanes the high byte.
    for (int i = 0; i < LANES; i++) begin
      w_payload[i*8 +: 8] = (i % 2 == 1) ? w_lfsr[15:8] : w_lfsr[7:0];
    end
    w_take_data = (int'(w_lfsr) % 100) < DATA_CHAR_PROBABILITY;
    w_k         = int'(w_lfsr[2:0]) % LANES;
    w_data      = {LANES{IDLE_CHAR}};
    w_ctrl      = '1;
    w_state_nxt = r_state;
    case (r_state)
      GS_IDLE: begin
        if (w_lfsr[0]) begin
          w_data      = w_payload;
          w_data[7:0] = START_CHAR;
          w_ctrl      = '0;
          w_ctrl[0]   = 1'b1;
          w_state_nxt = GS_DATA;
        end
      end
      GS_DATA: begin
        if (w_take_data) begin
          w_data = w_payload;
          w_ctrl = '0;
        end else begin
          for (int i = 0; i < LANES; i++) begin
            if (i < w_k) begin
              w_data[i*8 +: 8] = w_payload[i*8 +: 8];
              w_ctrl[i]        = 1'b0;
            end else if (i == w_k) begin
              w_data[i*8 +: 8] = TERM_CHAR;
            end
          end
          w_state_nxt = GS_GAP;
        end
      end
      GS_GAP:  w_state_nxt = GS_IDLE;
      default: w_state_nxt = GS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state <= GS_IDLE;
      r_data  <= {LANES{IDLE_CHAR}};
      r_ctrl  <= '1;
    end else begin
      r_state <= w_state_nxt;
      r_data  <= w_data;
      r_ctrl  <= w_ctrl;
    end
  end

  assign data_out = r_data;
  assign ctrl_out = r_ctrl;
endmodule
`default_nettype wire

// File: rtl/gmii_lfsr.sv
`default_nettype none
// ==== gmii_lfsr: 16-bit Fibonacci LFSR, taps 16/14/13/11, advances every cycle (rev 1.0) ====
module gmii_lfsr #(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  wire logic        clk,
  input  wire logic        rst_n,
  output logic [15:0]      o_lfsr
);
  logic [15:0] r_lfsr;
  logic        w_fb;

  assign w_fb   = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];
  assign o_lfsr = r_lfsr;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) r_lfsr <= SEED;
    else       r_lfsr <= {r_lfsr[14:0], w_fb};
  end
endmodule
`default_nettype wire

// File: rtl/gmii_traffic_pair.sv
`default_nettype none
// ==== gmii_traffic_pair: generator and checker; checker watches the generator or an external stream (rev 1.0) ====
module gmii_traffic_pair
  import gmii_pkg::*;
#(
  parameter int          DATA_WIDTH            = 64,
  parameter int          DATA_CHAR_PROBABILITY = 80,
  parameter logic [15:0] SEED                  = 16'hACE1
) (
  input  wire logic   clk,
  input  wire logic   rst_n,
  input  wire logic   i_start_monitoring,
  input  wire logic   i_loopback,
  gmii_if.slave       i_ext,
  gmii_if.master      o_gen,
  output logic        o_in_frame,
  output logic        o_error_pulse,
  output logic [31:0] o_frame_count,
  output logic [31:0] o_error_count
);
  logic [DATA_WIDTH-1:0]   w_gen_data, w_mon_data;
  logic [DATA_WIDTH/8-1:0] w_gen_ctrl, w_mon_ctrl;

  gmii_generator #(
    .DATA_WIDTH(DATA_WIDTH), .DATA_CHAR_PROBABILITY(DATA_CHAR_PROBABILITY), .SEED(SEED)
  ) u_gen (
    .clk(clk), .rst_n(rst_n), .data_out(w_gen_data), .ctrl_out(w_gen_ctrl)
  );

  assign o_gen.data = w_gen_data;
  assign o_gen.ctrl = w_gen_ctrl;
  assign w_mon_data = i_loopback ? w_gen_data : i_ext.data;
  assign w_mon_ctrl = i_loopback ? w_gen_ctrl : i_ext.ctrl;

  gmii_checker #(.DATA_WIDTH(DATA_WIDTH)) u_chk (
    .clk(clk), .rst_n(rst_n), .start_monitoring(i_start_monitoring),
    .data_in(w_mon_data), .ctrl_in(w_mon_ctrl),
    .in_frame(o_in_frame), .error_pulse(o_error_pulse),
    .frame_count(o_frame_count), .error_count(o_error_count)
  );
endmodule
`default_nettype wire

// File: tb/tb_gmii_traffic_pair.sv
`default_nettype none
`timescale 1ns/1ps
// ==== tb_gmii_traffic_pair: directed + randomized checks against a word-level reference model (rev 1.0) ====
module tb_gmii_traffic_pair;
  localparam logic [63:0] IDLE_W = 64'h0707070707070707;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic mon = 1'b0;
  logic loop = 1'b0;
  always #5 clk = ~clk;

  gmii_if #(.DATA_WIDTH(64)) ext ();
  gmii_if #(.DATA_WIDTH(64)) gen ();
  gmii_if #(.DATA_WIDTH(64)) ext0 ();
  gmii_if #(.DATA_WIDTH(64)) gen0 ();
  gmii_if #(.DATA_WIDTH(64)) ext100 ();
  gmii_if #(.DATA_WIDTH(64)) gen100 ();
  assign ext0.data = IDLE_W;   assign ext0.ctrl = 8'hFF;
  assign ext100.data = IDLE_W; assign ext100.ctrl = 8'hFF;

  logic inf, pulse, inf0, pulse0, inf100, pulse100;
  logic [31:0] fc, ec, fc0, ec0, fc100, ec100;

  gmii_traffic_pair #(.DATA_WIDTH(64)) u_dut (
    .clk(clk), .rst_n(rst_n), .i_start_monitoring(mon), .i_loopback(loop),
    .i_ext(ext), .o_gen(gen), .o_in_frame(inf), .o_error_pulse(pulse),
    .o_frame_count(fc), .o_error_count(ec));
  gmii_traffic_pair #(.DATA_WIDTH(64), .DATA_CHAR_PROBABILITY(0)) u_p0 (
    .clk(clk), .rst_n(rst_n), .i_start_monitoring(1'b1), .i_loopback(1'b1),
    .i_ext(ext0), .o_gen(gen0), .o_in_frame(inf0), .o_error_pulse(pulse0),
    .o_frame_count(fc0), .o_error_count(ec0));
  gmii_traffic_pair #(.DATA_WIDTH(64), .DATA_CHAR_PROBABILITY(100)) u_p100 (
    .clk(clk), .rst_n(rst_n), .i_start_monitoring(1'b1), .i_loopback(1'b1),
    .i_ext(ext100), .o_gen(gen100), .o_in_frame(inf100), .o_error_pulse(pulse100),
    .o_frame_count(fc100), .o_error_count(ec100));

  int checks = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // 0 idle, 1 start, 2 data, 3 terminate, 4 anything else
  function automatic int bench_kind(input logic [63:0] d, input logic [7:0] c);
    logic [7:0] tmask;
    if (c == 8'h00) return 2;
    if (c == 8'hFF && d == IDLE_W) return 0;
    if (c == 8'h01 && d[7:0] == 8'hFB) return 1;
    for (int k = 0; k < 8; k++) begin
      tmask = 8'hFF << k;
      if (c == tmask && d[8*k +: 8] == 8'hFD && (d >> (8*k+8)) == (IDLE_W >> (8*k+8))) return 3;
    end
    return 4;
  endfunction

  function automatic logic [63:0] term_w(input int k, input logic [63:0] pay);
    logic [63:0] d;
    d = IDLE_W;
    for (int i = 0; i < k; i++) d[8*i +: 8] = pay[8*i +: 8];
    d[8*k +: 8] = 8'hFD;
    return d;
  endfunction

  // Checker reference model
  bit m_in, m_pulse;
  int m_fc, m_ec;

  task automatic model_reset();
    m_in = 0; m_pulse = 0; m_fc = 0; m_ec = 0;
  endtask

  task automatic model_word(input logic [63:0] d, input logic [7:0] c);
    int  kind;
    bit  err, good;
    kind = bench_kind(d, c);
    err = 0; good = 0;
    if (!m_in) begin
      if (kind == 1) m_in = 1;
      else if (kind != 0) err = 1;
    end else begin
      if (kind == 3) begin good = 1; m_in = 0; end
      else if (kind == 1) err = 1;
      else if (kind != 2) begin err = 1; m_in = 0; end
    end
    for (int i = 0; i < 8; i++) if (c[i] && d[8*i +: 8] == 8'hFE) err = 1;
    m_pulse = err;
    if (mon) begin
      if (good) m_fc++;
      if (err)  m_ec++;
    end
  endtask

  task automatic check_chk(input string tag);
    chk({tag, ".in_frame"}, inf, m_in);
    chk({tag, ".error_pulse"}, pulse, m_pulse);
    chk({tag, ".frame_count"}, fc, m_fc);
    chk({tag, ".error_count"}, ec, m_ec);
  endtask

  task automatic send(input string tag, input logic [63:0] d, input logic [7:0] c);
    ext.data = d; ext.ctrl = c;
    model_word(d, c);
    @(posedge clk); #1;
    check_chk(tag);
  endtask

  // Generator reference model (P = 80, seed ACE1)
  logic [15:0] g_l;
  int          g_st;

  task automatic gen_step(output logic [63:0] d, output logic [7:0] c);
    logic [63:0] pay;
    int k;
    for (int i = 0; i < 8; i++) pay[8*i +: 8] = (i % 2 == 1) ? g_l[15:8] : g_l[7:0];
    d = IDLE_W; c = 8'hFF;
    if (g_st == 0) begin
      if (g_l[0]) begin d = {pay[63:8], 8'hFB}; c = 8'h01; g_st = 1; end
    end else if (g_st == 1) begin
      if (int'(g_l) % 100 < 80) begin d = pay; c = 8'h00; end
      else begin k = int'(g_l[2:0]); d = term_w(k, pay); c = 8'hFF << k; g_st = 2; end
    end else begin
      g_st = 0;
    end
    g_l = {g_l[14:0], g_l[15] ^ g_l[13] ^ g_l[12] ^ g_l[10]};
  endtask

  task automatic rand_word(output logic [63:0] d, output logic [7:0] c);
    logic [63:0] pay;
    int sel, k;
    pay = {$urandom, $urandom};
    sel = $urandom_range(0, 9);
    if (sel < 2)      begin d = IDLE_W; c = 8'hFF; end
    else if (sel < 4) begin d = {pay[63:8], 8'hFB}; c = 8'h01; end
    else if (sel < 7) begin d = pay; c = 8'h00; end
    else if (sel < 9) begin k = $urandom_range(0, 7); d = term_w(k, pay); c = 8'hFF << k; end
    else begin
      d = pay; c = 8'($urandom);
      k = $urandom_range(0, 7);
      if ($urandom_range(0, 1) == 1) begin d[8*k +: 8] = 8'hFE; c[k] = 1'b1; end
    end
  endtask

  // Stream properties of the P=0 and P=100 generators
  int p0_starts = 0, p0_bad = 0, p100_starts = 0, p100_terms = 0;
  bit p0_prev_start = 0, p100_seen = 0;
  always @(posedge clk) begin
    int k0, k100;
    #1;
    if (rst_n) begin
      p0_prev_start = 0; p100_seen = 0;
    end else begin
      k0 = bench_kind(gen0.data, gen0.ctrl);
      if (p0_prev_start && k0 != 3) p0_bad++;
      p0_prev_start = (k0 == 1);
      if (k0 == 1) p0_starts++;
      k100 = bench_kind(gen100.data, gen100.ctrl);
      if (k100 == 1) begin p100_seen = 1; p100_starts++; end
      else if (k100 == 3 && p100_seen) p100_terms++;
    end
  end

  initial begin
    logic [63:0] d, pd, ed;
    logic [7:0]  c, pc, ecw;
    int saved_ec, saved_fc;
    ext.data = IDLE_W; ext.ctrl = 8'hFF;
    model_reset();

    repeat (3) @(posedge clk);
    #1;
    chk("rst.data_out", gen.data, 64'h0707070707070707);
    chk("rst.ctrl_out", gen.ctrl, 8'hFF);
    check_chk("rst");

    @(negedge clk); rst_n = 1'b0; mon = 1'b1;
    send("dir.idle",  IDLE_W, 8'hFF);
    send("dir.start", 64'h11223344556677FB, 8'h01);
    send("dir.data",  64'hDEADBEEFCAFEF00D, 8'h00);
    send("dir.term3", term_w(3, 64'h0000000000A1B2C3), 8'hF8);
    chk("dir.frame_count_1", fc, 1);
    chk("dir.error_count_0", ec, 0);

    send("err.data_out", 64'h0102030405060708, 8'h00);
    chk("err.pulse_high", pulse, 1);
    chk("err.count_1", ec, 1);
    send("err.idle_after", IDLE_W, 8'hFF);
    chk("err.pulse_one_cycle", pulse, 0);
    send("err.start1", 64'h00000000000000FB, 8'h01);
    send("err.start2", 64'hFFFFFFFFFFFFFFFB, 8'h01);
    chk("err.start_in_frame", inf, 1);
    chk("err.start_pulse", pulse, 1);

    mon = 1'b0;
    saved_ec = m_ec; saved_fc = m_fc;
    for (int i = 0; i < 5; i++) begin
      send("nomon.bad", {$urandom, $urandom}, 8'hAA);
      chk("nomon.pulse", pulse, 1);
      chk("nomon.error_count", ec, saved_ec);
      chk("nomon.frame_count", fc, saved_fc);
    end

    for (int i = 0; i < 300; i++) begin
      mon = ($urandom_range(0, 3) != 0);
      rand_word(d, c);
      send("rand", d, c);
    end

    mon = 1'b1;
    send("arst.start", 64'h55555555555555FB, 8'h01);
    chk("arst.in_frame_before", inf, 1);
    rst_n = 1'b1;
    #1;
    model_reset();
    check_chk("arst");
    chk("arst.data_out", gen.data, IDLE_W);
    chk("arst.ctrl_out", gen.ctrl, 8'hFF);
    ext.data = IDLE_W; ext.ctrl = 8'hFF;
    repeat (2) @(posedge clk);

    @(negedge clk);
    rst_n = 1'b0; loop = 1'b1;
    g_l = 16'hACE1; g_st = 0;
    pd = IDLE_W; pc = 8'hFF;
    for (int i = 0; i < 1000; i++) begin
      @(posedge clk); #1;
      model_word(pd, pc);
      gen_step(ed, ecw);
      chk("loop.data_out", gen.data, ed);
      chk("loop.ctrl_out", gen.ctrl, ecw);
      check_chk("loop");
      pd = ed; pc = ecw;
    end
    chk("loop.error_count_zero", ec, 0);
    chk("loop.frames_seen", fc > 0, 1);

    chk("p0.starts_seen", p0_starts > 0, 1);
    chk("p0.start_then_term", p0_bad, 0);
    chk("p0.checker_errors", ec0, 0);
    chk("p0.checker_frames", fc0 > 0, 1);
    chk("p100.start_seen", p100_starts > 0, 1);
    chk("p100.no_term", p100_terms, 0);
    chk("p100.checker_errors", ec100, 0);
    chk("p100.checker_frames", fc100, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/gmii_traffic_pair.md
# gmii_traffic_pair

Synthesizable XGMII-style traffic source (`gmii_generator`) and protocol monitor (`gmii_checker`) for the MII verification area. The generator emits a pseudo-random stream of idle, start, data and terminate words, one word per clock. The checker watches any such stream, validates frame framing per word, and counts frames and violations. Both modules share one clock and one reset and are normally connected back-to-back.

## Interface

All ports use one clock; reset is asynchronous and active-high. The reset port keeps the codebase name `rst_n` but is asserted high.

Parameters:
- `DATA_WIDTH`, default 64: bus width in bits. Must be a multiple of 8. Lanes L = DATA_WIDTH/8.
- `DATA_CHAR_PROBABILITY`, default 80 (generator only): percent chance, 0..100, that an in-frame word is an all-data word.
- `SEED`, default 16'hACE1 (generator only): LFSR seed. Must be nonzero.

`gmii_generator` ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async reset, active-high
- `data_out`  out  DATA_WIDTH  byte lanes; lane 0 = bits [7:0]
- `ctrl_out`  out  L  per-lane flag; 1 = control character

`gmii_checker` ports:
- `clk`  in  1  clock
- `rst_n`  in  1  async reset, active-high
- `start_monitoring`  in  1  enables counting
- `data_in`  in  DATA_WIDTH  monitored data
- `ctrl_in`  in  L  monitored control flags
- `in_frame`  out  1  checker framing state
- `error_pulse`  out  1  one-cycle flag for a violating word
- `frame_count`  out  32  good frames counted
- `error_count`  out  32  violations counted

## Operation

Control characters: IDLE 8'h07, START 8'hFB, TERM 8'hFD, ERROR 8'hFE.

Word classes:
- Idle word: every lane is IDLE, ctrl all 1.
- Start word: lane 0 is START with ctrl[0]=1; lanes 1..L-1 are data with ctrl 0.
- Data word: all ctrl bits are 0; any byte values.
- Terminate word at lane k (0..L-1): lanes below k are data with ctrl 0; lane k is TERM with ctrl 1; lanes above k are IDLE with ctrl 1.

Generator:
- Uses a 16-bit Fibonacci LFSR with taps 16,14,13,11, advanced every cycle. All random choices and data bytes come from the LFSR.
- States are IDLE, DATA and GAP.
- IDLE: emits an idle word. If lfsr[0]=1, moves to DATA and emits a start word next.
- DATA: if (lfsr[15:0] % 100) < DATA_CHAR_PROBABILITY, emits a data word and stays in DATA. Otherwise emits a terminate word with k = lfsr[2:0] % L and moves to GAP.
- GAP: emits exactly one idle word, then moves to IDLE.
- The generator never emits the ERROR character.

Checker:
- Framing state (OUT, IN) is tracked every cycle whether or not `start_monitoring` is high.
- OUT state: an idle word stays OUT. A start word moves to IN. Any other word is an error and stays OUT.
- IN state: a data word stays IN. A terminate word is a good frame and moves to OUT. A start word is an error and stays IN, beginning a new frame. Any other word is an error and moves to OUT.
- Any lane carrying ERROR with ctrl 1 is an error.
- When `start_monitoring`=1, each good frame increments `frame_count` and each error increments `error_count`. Counters saturate at all-ones.
- `error_pulse` asserts for any error, independent of `start_monitoring`.
- In simulation only, each error issues `$error` with the sim time, data and ctrl values.

## Timing

- Generator outputs are registered. Reset values: `data_out` = 0x07 in every lane, `ctrl_out` = all ones, state IDLE, LFSR = SEED. The first start word appears no earlier than the 2nd cycle after reset release.
- Checker inputs are sampled on the rising edge. `in_frame`, `error_pulse` and the counters update on that same edge, i.e. one cycle after the word is present on the inputs.
- Checker reset values: all outputs 0, state OUT.
- Reset asserted mid-frame returns both blocks to their reset state immediately (asynchronous).
- Deasserting `start_monitoring` freezes the counters at their current values. Framing continues to be tracked.

## Structure

- Package `gmii_pkg` holds the four control-character constants, a framing-state enum and a word-classify function (idle/start/data/term-k/invalid) used by both modules.
- Sub-module `gmii_lfsr` (16-bit, SEED parameter) is instantiated inside the generator.

## Test plan

- Reset held 3 cycles -> `data_out` = 64'h0707070707070707, `ctrl_out` = 8'hFF, all checker outputs 0.
- Generator connected to checker, start_monitoring=1, 1000 cycles -> `error_count` = 0 and `frame_count` > 0.
- Directed words into the checker: idle; start (ctrl 8'h01); data; terminate at k=3 (ctrl 8'hF8) -> `frame_count` = 1, `error_count` = 0.
- Data word while OUT -> `error_pulse` high one cycle, `error_count` = 1. Start word while IN -> error, `in_frame` stays 1.
- start_monitoring=0 during five bad words -> counters unchanged; `error_pulse` still fires each cycle.
- DATA_CHAR_PROBABILITY=0 -> every start is followed immediately by a terminate. DATA_CHAR_PROBABILITY=100 -> no terminate after the first start.
